// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets,
// control/status bit positions and the register-select decode.
package timer_pkg;

  localparam int CH_STRIDE_DEF = 'h40;

  // Register offsets inside one channel bank
  localparam logic [7:0] OFF_CR  = 8'h00;
  localparam logic [7:0] OFF_PSC = 8'h08;
  localparam logic [7:0] OFF_ARR = 8'h10;
  localparam logic [7:0] OFF_CNT = 8'h18;
  localparam logic [7:0] OFF_SR  = 8'h20;

  // CR bit positions
  localparam int CR_EN  = 0;
  localparam int CR_OPM = 1;
  localparam int CR_UIE = 2;
  localparam int CR_W   = 3;

  // SR bit positions
  localparam int SR_UIF = 0;

  typedef enum logic [2:0] {
    REG_CR,
    REG_PSC,
    REG_ARR,
    REG_CNT,
    REG_SR,
    REG_NONE
  } reg_sel_e;

  // Map an in-bank offset to the register it selects
  function automatic reg_sel_e decode_off(input logic [7:0] off);
    case (off)
      OFF_CR:  return REG_CR;
      OFF_PSC: return REG_PSC;
      OFF_ARR: return REG_ARR;
      OFF_CNT: return REG_CNT;
      OFF_SR:  return REG_SR;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/prescaler/reload/counter/status registers,
// prescaler tick generation, reload handling and the level interrupt.
module timer_channel
  import timer_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                wen,
  input  reg_sel_e            wsel,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [CR_W-1:0]     cr_o,
  output logic [DATA_W-1:0]   psc_o,
  output logic [DATA_W-1:0]   arr_o,
  output logic [DATA_W-1:0]   cnt_o,
  output logic                uif_o,
  output logic                irq_o
);

  logic [CR_W-1:0]   cr_q, cr_d;
  logic [DATA_W-1:0] psc_q, psc_d;
  logic [DATA_W-1:0] arr_q, arr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pcnt_q, pcnt_d;
  logic              uif_q, uif_d;
  logic [DATA_W-1:0] wmask;
  logic              tick;
  logic              uif_set;
  logic              uif_clr;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [DATA_W-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      wmask[i*8 +: 8] = {8{wstrb[i]}};
    end
  end

  // Next-state: prescaler and counter first, then software writes override
  always_comb begin
    cr_d    = cr_q;
    psc_d   = psc_q;
    arr_d   = arr_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    uif_set = 1'b0;
    uif_clr = 1'b0;
    // >= rather than == keeps the prescaler from running away if PSC is
    // lowered below the current prescaler count.
    tick    = cr_q[CR_EN] && (pcnt_q >= psc_q);

    if (cr_q[CR_EN]) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    if (tick) begin
      if (cnt_q >= arr_q) begin
        cnt_d   = '0;
        uif_set = 1'b1;
        if (cr_q[CR_OPM]) begin
          cr_d[CR_EN] = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (wen) begin
      case (wsel)
        REG_CR: begin
          // All CR bits live in byte lane 0
          if (wstrb[0]) begin
            cr_d = wdata[CR_W-1:0];
            if (!cr_q[CR_EN] && wdata[CR_EN]) begin
              pcnt_d = '0;
            end
          end
        end
        REG_PSC: psc_d = merge(psc_q, wdata, wmask);
        REG_ARR: arr_d = merge(arr_q, wdata, wmask);
        REG_CNT: cnt_d = merge(cnt_q, wdata, wmask);
        REG_SR:  uif_clr = wstrb[0] && wdata[SR_UIF];
        default: ;
      endcase
    end

    // A hardware update event wins over a coincident software clear
    uif_d = uif_set ? 1'b1 : (uif_clr ? 1'b0 : uif_q);
  end

  // Channel register state
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cr_q   <= '0;
      psc_q  <= '0;
      arr_q  <= '0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      uif_q  <= 1'b0;
    end else begin
      cr_q   <= cr_d;
      psc_q  <= psc_d;
      arr_q  <= arr_d;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      uif_q  <= uif_d;
    end
  end

  assign cr_o  = cr_q;
  assign psc_o = psc_q;
  assign arr_o = arr_q;
  assign cnt_o = cnt_q;
  assign uif_o = uif_q;
  assign irq_o = uif_q & cr_q[CR_UIE];

endmodule

// File: rtl/timer_multi.sv
// N-channel timer peripheral: address decode, write fan-out to channels,
// registered read mux, ready pulses and combined interrupt.
// Handshake: a request is a one-cycle WriteEnable/ReadEnable; the matching
// SlaverWriteReady/SlaverReadReady is high for exactly the following cycle,
// with ReadData valid while SlaverReadReady is high. Requests are never stalled.
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int CH_STRIDE = CH_STRIDE_DEF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [DATA_W-1:0]   WriteAddr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic                WriteEnable,
  input  logic [DATA_W/8-1:0] WriteStrb,
  output logic                SlaverWriteReady,
  input  logic [DATA_W-1:0]   ReadAddr,
  input  logic                ReadEnable,
  output logic [DATA_W-1:0]   ReadData,
  output logic                SlaverReadReady,
  output logic [NUM_CH-1:0]   TimerIrq,
  output logic                TimerIrqAny
);

  localparam logic [DATA_W-1:0] STRIDE_W = DATA_W'(CH_STRIDE);
  localparam logic [DATA_W-1:0] NUM_CH_W = DATA_W'(NUM_CH);

  logic [DATA_W-1:0] wr_ch, wr_off, rd_ch, rd_off;
  reg_sel_e          wr_sel, rd_sel;
  logic              wr_hit;
  logic [NUM_CH-1:0] ch_wen;

  logic [CR_W-1:0]   ch_cr  [NUM_CH];
  logic [DATA_W-1:0] ch_psc [NUM_CH];
  logic [DATA_W-1:0] ch_arr [NUM_CH];
  logic [DATA_W-1:0] ch_cnt [NUM_CH];
  logic              ch_uif [NUM_CH];

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rready_q, rready_d;
  logic              wready_q, wready_d;

  // Split both addresses into channel index and in-bank register select
  always_comb begin
    wr_ch  = WriteAddr / STRIDE_W;
    wr_off = WriteAddr % STRIDE_W;
    rd_ch  = ReadAddr / STRIDE_W;
    rd_off = ReadAddr % STRIDE_W;
    wr_sel = ((wr_off >> 8) == '0) ? decode_off(wr_off[7:0]) : REG_NONE;
    rd_sel = ((rd_off >> 8) == '0) ? decode_off(rd_off[7:0]) : REG_NONE;
    wr_hit = WriteEnable && (wr_ch < NUM_CH_W) && (wr_sel != REG_NONE);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_wen[g] = wr_hit && (wr_ch == DATA_W'(g));

    timer_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .wen     (ch_wen[g]),
      .wsel    (wr_sel),
      .wdata   (WriteData),
      .wstrb   (WriteStrb),
      .cr_o    (ch_cr[g]),
      .psc_o   (ch_psc[g]),
      .arr_o   (ch_arr[g]),
      .cnt_o   (ch_cnt[g]),
      .uif_o   (ch_uif[g]),
      .irq_o   (TimerIrq[g])
    );
  end

  // Read mux; unmapped channels or offsets fall through to zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == DATA_W'(i)) begin
        case (rd_sel)
          REG_CR:  rd_val = {{(DATA_W-CR_W){1'b0}}, ch_cr[i]};
          REG_PSC: rd_val = ch_psc[i];
          REG_ARR: rd_val = ch_arr[i];
          REG_CNT: rd_val = ch_cnt[i];
          REG_SR:  rd_val = {{(DATA_W-1){1'b0}}, ch_uif[i]};
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Ready pulses and read data for the cycle after a request
  always_comb begin
    wready_d = WriteEnable;
    rready_d = ReadEnable;
    rdata_d  = ReadEnable ? rd_val : '0;
  end

  // Bus response registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wready_q <= 1'b0;
      rready_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wready_q <= wready_d;
      rready_q <= rready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign SlaverWriteReady = wready_q;
  assign SlaverReadReady  = rready_q;
  assign ReadData         = rdata_q;
  assign TimerIrqAny      = |TimerIrq;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: read results go through an expected queue
// that is filled when a read is issued and drained when read data returns.
module tb_timer_multi;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;

  logic              ACLK;
  logic              ARESETn;
  logic [DATA_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              WriteEnable;
  logic [7:0]        WriteStrb;
  logic              SlaverWriteReady;
  logic [DATA_W-1:0] ReadAddr;
  logic              ReadEnable;
  logic [DATA_W-1:0] ReadData;
  logic              SlaverReadReady;
  logic [NUM_CH-1:0] TimerIrq;
  logic              TimerIrqAny;

  logic [DATA_W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  timer_multi #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .CH_STRIDE ('h40)
  ) dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .WriteAddr        (WriteAddr),
    .WriteData        (WriteData),
    .WriteEnable      (WriteEnable),
    .WriteStrb        (WriteStrb),
    .SlaverWriteReady (SlaverWriteReady),
    .ReadAddr         (ReadAddr),
    .ReadEnable       (ReadEnable),
    .ReadData         (ReadData),
    .SlaverReadReady  (SlaverReadReady),
    .TimerIrq         (TimerIrq),
    .TimerIrqAny      (TimerIrqAny)
  );

  // Clock and watchdog
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle with an optional write and an optional read
  task automatic cyc(input logic we, input logic [DATA_W-1:0] wa,
                     input logic [DATA_W-1:0] wd, input logic [7:0] ws,
                     input logic re, input logic [DATA_W-1:0] ra,
                     input logic [DATA_W-1:0] rexp);
    WriteEnable = we;
    WriteAddr   = wa;
    WriteData   = wd;
    WriteStrb   = ws;
    ReadEnable  = re;
    ReadAddr    = ra;
    if (re) exp_q.push_back(rexp);
    @(posedge ACLK);
    #1;
    WriteEnable = 1'b0;
    ReadEnable  = 1'b0;
    if (we) check("wr_ready", {63'd0, SlaverWriteReady}, 64'd1);
  endtask

  task automatic wr(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    cyc(1'b1, a, d, 8'hFF, 1'b0, '0, '0);
  endtask

  task automatic wr_s(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [7:0] s);
    cyc(1'b1, a, d, s, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    cyc(1'b0, '0, '0, 8'h00, 1'b1, a, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic check_irq(input string tag, input logic [NUM_CH-1:0] e);
    check(tag, {60'd0, TimerIrq}, {60'd0, e});
    check({tag, "_any"}, {63'd0, TimerIrqAny}, {63'd0, (|e)});
  endtask

  // Scoreboard: compare returning read data against the oldest expectation
  always @(negedge ACLK) begin
    if (ARESETn && SlaverReadReady) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rd_unexpected: observed data %h expected no read", ReadData);
      end
      if (exp_q.size() != 0) check("rd_data", ReadData, exp_q.pop_front());
    end
  end

  initial begin
    ARESETn     = 1'b0;
    WriteAddr   = '0;
    WriteData   = '0;
    WriteEnable = 1'b0;
    WriteStrb   = '0;
    ReadAddr    = '0;
    ReadEnable  = 1'b0;

    // Reset state
    idle(3);
    check_irq("rst_irq", 4'b0000);
    check("rst_wready", {63'd0, SlaverWriteReady}, 64'd0);
    check("rst_rready", {63'd0, SlaverReadReady}, 64'd0);
    check("rst_rdata", ReadData, 64'd0);
    ARESETn = 1'b1;
    idle(1);
    rd(64'h00, 0); rd(64'h08, 0); rd(64'h10, 0); rd(64'h18, 0); rd(64'h20, 0);

    // Ch0 auto-reload, PSC=0 ARR=3 with interrupt enabled
    wr(64'h08, 0);
    wr(64'h10, 3);
    wr(64'h00, 5);
    rd(64'h18, 0);
    rd(64'h18, 1);
    rd(64'h18, 2);
    check_irq("ch0_pre_wrap", 4'b0000);
    rd(64'h18, 3);
    check_irq("ch0_wrap", 4'b0001);
    rd(64'h18, 0);
    wr(64'h00, 4);
    rd(64'h18, 2);
    check_irq("ch0_hold", 4'b0001);
    wr(64'h20, 1);
    check_irq("ch0_w1c", 4'b0000);
    rd(64'h20, 0);
    rd(64'h00, 4);

    // Ch1 one-shot, PSC=2 ARR=1
    wr(64'h48, 2);
    wr(64'h50, 1);
    wr(64'h40, 3);
    idle(5);
    rd(64'h60, 0);
    rd(64'h60, 1);
    rd(64'h40, 2);
    rd(64'h58, 0);
    idle(3);
    rd(64'h58, 0);
    check_irq("ch1_no_uie", 4'b0000);
    wr(64'h60, 1);
    rd(64'h60, 0);

    // Ch2 W1C coincident with a wrap tick
    wr(64'h88, 0);
    wr(64'h90, 3);
    wr(64'h80, 5);
    idle(7);
    wr(64'ha0, 1);
    check_irq("ch2_w1c_vs_set", 4'b0100);
    wr(64'h80, 4);
    wr(64'ha0, 1);
    check_irq("ch2_w1c", 4'b0000);
    rd(64'ha0, 0);

    // Ch3 ARR lowered below CNT wraps on next tick
    wr(64'hc8, 0);
    wr(64'hd0, 10);
    wr(64'hd8, 5);
    wr(64'hd0, 2);
    wr(64'hc0, 1);
    rd(64'hd8, 5);
    rd(64'hd8, 0);
    rd(64'he0, 1);
    wr(64'hc0, 0);
    // Byte-lane strobes and unused CR bits
    wr(64'hd8, 64'h1234);
    wr_s(64'hd8, 64'haaaa_aaaa_aaaa_aaaa, 8'h02);
    rd(64'hd8, 64'haa34);
    wr(64'hc0, 64'hffff_fff8);
    rd(64'hc0, 0);
    wr(64'he0, 1);

    // Read and write of the same register in one cycle
    cyc(1'b1, 64'h10, 9, 8'hFF, 1'b1, 64'h10, 3);
    rd(64'h10, 9);

    // Unmapped channel and unmapped offset
    wr(64'h110, 64'h55);
    check("unmapped_wready_pulse", {63'd0, SlaverWriteReady}, 64'd1);
    idle(1);
    check("wready_single", {63'd0, SlaverWriteReady}, 64'd0);
    wr(64'h28, 64'h77);
    rd(64'h110, 0);
    rd(64'h28, 0);
    idle(1);
    check("rready_single", {63'd0, SlaverReadReady}, 64'd0);
    rd(64'h10, 9);
    rd(64'h18, 2);
    rd(64'h00, 4);

    // Reset while counting with UIF set
    wr(64'h10, 0);
    wr(64'h00, 5);
    wr(64'h00, 4);
    wr(64'h18, 7);
    wr(64'h10, 100);
    wr(64'h00, 5);
    check_irq("pre_reset_irq", 4'b0001);
    idle(1);
    ARESETn = 1'b0;
    idle(1);
    check_irq("mid_reset_irq", 4'b0000);
    check("mid_reset_rready", {63'd0, SlaverReadReady}, 64'd0);
    ARESETn = 1'b1;
    rd(64'h18, 0);
    rd(64'h20, 0);
    rd(64'h00, 0);
    rd(64'h10, 0);
    rd(64'h48, 0);
    idle(2);
    check_irq("post_reset_irq", 4'b0000);
    check("rd_pending", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
